// File: rtl/bram_result_streamer_if.sv
// Bundles bram1 read-port and output-stream signals of the result streamer.
// master = the streamer; slave = the BRAM/DMA side that surrounds it.
interface bram_result_streamer_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        bram_en;
    logic [31:0] bram_addr;
    logic [31:0] bram_dout;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    modport master (
        input  start, bram_dout, m_tready,
        output busy, done, bram_en, bram_addr, m_tdata, m_tvalid, m_tlast
    );

    modport slave (
        output start, bram_dout, m_tready,
        input  busy, done, bram_en, bram_addr, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/bram_result_streamer.sv
// Drains the conv result buffer over a second bram1 read port and streams it out
// as 32-bit valid/ready words, with a credit-limited prefetch FIFO for backpressure.
module bram_result_streamer #(
    parameter int          IMG_WIDTH  = 256,
    parameter int          IMG_HEIGHT = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bram_result_streamer_if.master io
);

    localparam int N  = IMG_WIDTH * IMG_HEIGHT;
    localparam int IW = $clog2(N + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e                       state_q, state_d;
    logic [IW-1:0]                rd_idx_q, rd_idx_d;
    logic [IW-1:0]                tx_idx_q, tx_idx_d;
    logic [31:0]                  addr_q, addr_d;
    logic                         done_q, done_d;
    logic                         inflight_q;
    logic [CW-1:0]                cnt_q;
    logic [PW-1:0]                wptr_q, rptr_q;
    logic [FIFO_DEPTH-1:0][31:0]  mem_q;

    logic        start_ok, issue, push, pop;
    logic [31:0] cur_addr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Credits cover words already buffered plus the read whose data arrives next edge,
    // so a push always finds room.
    assign start_ok = io.start && (state_q == IDLE) && !done_q;
    assign issue    = (state_q == RUN) &&
                      ((32'(cnt_q) + 32'(inflight_q)) < 32'(FIFO_DEPTH));
    assign push     = inflight_q;
    assign pop      = (cnt_q != '0) && io.m_tready;
    assign cur_addr = BASE_ADDR + (32'(rd_idx_q) << 2);

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        tx_idx_d = tx_idx_q;
        addr_d   = addr_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d  = RUN;
                    rd_idx_d = '0;
                    tx_idx_d = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    rd_idx_d = rd_idx_q + IW'(1);
                    addr_d   = cur_addr;
                    if (rd_idx_q == LAST_IDX) state_d = DRAIN;
                end
            end
            DRAIN: ;
            default: state_d = IDLE;
        endcase
        if (pop && state_q != IDLE) begin
            tx_idx_d = tx_idx_q + IW'(1);
            if (state_q == DRAIN && tx_idx_q == LAST_IDX) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_idx_q   <= '0;
            tx_idx_q   <= '0;
            addr_q     <= BASE_ADDR;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            tx_idx_q   <= tx_idx_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
            inflight_q <= issue;
        end
    end

    // bram_dout is valid while inflight_q is set and is captured unconditionally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= io.bram_dout;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop) rptr_q <= ptr_inc(rptr_q);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // busy stays up through the done cycle so a start there is ignored.
    assign io.busy      = (state_q != IDLE) || done_q;
    assign io.done      = done_q;
    assign io.bram_en   = issue;
    assign io.bram_addr = issue ? cur_addr : addr_q;
    assign io.m_tvalid  = (cnt_q != '0);
    assign io.m_tdata   = mem_q[rptr_q];
    assign io.m_tlast   = (cnt_q != '0) && (tx_idx_q == LAST_IDX);

endmodule

// File: tb/tb_bram_result_streamer.sv
// Directed bench for bram_result_streamer: 4x4, 64x64 (random ready) and 1x1 instances,
// each with a small BRAM model whose contents are a known function of the address.
module tb_bram_result_streamer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bram_result_streamer_if a ();
    bram_result_streamer_if b ();
    bram_result_streamer_if c ();

    bram_result_streamer #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .BASE_ADDR(32'h100), .FIFO_DEPTH(4))
        dut_a (.clk(clk), .rst_n(rst_n), .io(a));
    bram_result_streamer #(.IMG_WIDTH(64), .IMG_HEIGHT(64), .BASE_ADDR(32'h0001_0000), .FIFO_DEPTH(4))
        dut_b (.clk(clk), .rst_n(rst_n), .io(b));
    bram_result_streamer #(.IMG_WIDTH(1), .IMG_HEIGHT(1), .BASE_ADDR(32'h0), .FIFO_DEPTH(4))
        dut_c (.clk(clk), .rst_n(rst_n), .io(c));

    function automatic logic [31:0] big_word(input logic [31:0] addr);
        return {addr[15:0], ~addr[15:0]};
    endfunction

    always_ff @(posedge clk) if (a.bram_en) a.bram_dout <= 32'hA000_0000 + ((a.bram_addr - 32'h100) >> 2);
    always_ff @(posedge clk) if (b.bram_en) b.bram_dout <= big_word(b.bram_addr);
    always_ff @(posedge clk) if (c.bram_en) c.bram_dout <= 32'hC0DE_0000 + (c.bram_addr >> 2);

    logic ovf = 1'b0;
    always @(posedge clk) if (dut_a.cnt_q > 4 || dut_b.cnt_q > 4) ovf <= 1'b1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [31:0] got_d[$];
    logic        got_l[$];
    logic [31:0] got_a[$];
    int          done_cyc[$];
    int          en_stall, frz_bad, busy_end;

    // Cycle c is the interval between edges E(c-1) and E(c); start is sampled at E0.
    task automatic run4(input int stl_lo, input int stl_hi, input logic [63:0] stmask, input int ncyc);
        got_d.delete(); got_l.delete(); got_a.delete(); done_cyc.delete();
        en_stall = 0; frz_bad = 0;
        @(negedge clk); a.start = 1'b1; a.m_tready = 1'b1;
        @(posedge clk); #1 a.start = 1'b0;
        for (int cy = 1; cy <= ncyc; cy++) begin
            a.m_tready = !(cy >= stl_lo && cy <= stl_hi);
            a.start    = (cy < 64) ? stmask[cy] : 1'b0;
            @(negedge clk);
            if (a.bram_en) got_a.push_back(a.bram_addr);
            if (a.m_tvalid && a.m_tready) begin
                got_d.push_back(a.m_tdata);
                got_l.push_back(a.m_tlast);
            end
            if (a.done) done_cyc.push_back(cy);
            if (cy >= stl_lo + 2 && cy <= stl_hi && a.bram_en) en_stall++;
            if (cy >= stl_lo && cy <= stl_hi && a.m_tdata != 32'hA000_0000) frz_bad++;
            @(posedge clk); #1;
        end
        a.start = 1'b0; a.m_tready = 1'b1;
        busy_end = int'(a.busy);
    endtask

    task automatic chk_seq(input string tag, input int copies);
        chk({tag, "_nwords"}, got_d.size(), 16 * copies);
        chk({tag, "_naddr"}, got_a.size(), 16 * copies);
        for (int i = 0; i < got_d.size(); i++) begin
            chk({tag, "_data"}, got_d[i], 32'hA000_0000 + (i % 16));
            chk({tag, "_last"}, got_l[i], (i % 16) == 15);
        end
        for (int i = 0; i < got_a.size(); i++)
            chk({tag, "_addr"}, got_a[i], 32'h100 + 4 * (i % 16));
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_busy"}, a.busy, 0);
        chk({tag, "_done"}, a.done, 0);
        chk({tag, "_en"}, a.bram_en, 0);
        chk({tag, "_valid"}, a.m_tvalid, 0);
        chk({tag, "_last"}, a.m_tlast, 0);
        chk({tag, "_tdata"}, a.m_tdata, 0);
        chk({tag, "_addr"}, a.bram_addr, 32'h100);
    endtask

    initial begin
        rst_n = 1'b0;
        a.start = 0; a.m_tready = 1;
        b.start = 0; b.m_tready = 0;
        c.start = 0; c.m_tready = 1;
        repeat (3) @(posedge clk);
        #1 chk_reset_a("rst");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Unthrottled 4x4 drain.
        run4(0, -1, 64'd0, 22);
        chk_seq("s1", 1);
        chk("s1_ndone", done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk("s1_done_cyc", done_cyc[0], 19);
        chk("s1_busy_after", busy_end, 0);

        // Ready low in cycles 3..12: credits stop issue after 4 reads, head frozen.
        run4(3, 12, 64'd0, 35);
        chk_seq("s2", 1);
        chk("s2_en_stall", en_stall, 0);
        chk("s2_frozen", frz_bad, 0);
        chk("s2_ndone", done_cyc.size(), 1);

        // Starts at 5, 18 and 19 (done cycle) ignored; start at 20 runs a second drain.
        run4(0, -1, (64'd1 << 5) | (64'd1 << 18) | (64'd1 << 19) | (64'd1 << 20), 45);
        chk_seq("s4", 2);
        chk("s4_ndone", done_cyc.size(), 2);
        if (done_cyc.size() > 1) begin
            chk("s4_done1", done_cyc[0], 19);
            chk("s4_done2", done_cyc[1], 39);
        end

        // Async reset in cycle 8 of a drain.
        begin
            int dn;
            dn = 0;
            @(negedge clk); a.start = 1'b1;
            @(posedge clk); #1 a.start = 1'b0;
            repeat (7) @(posedge clk);
            #1 rst_n = 1'b0;
            #1 chk_reset_a("mid_rst");
            @(negedge clk) rst_n = 1'b1;
            for (int i = 0; i < 25; i++) begin
                @(negedge clk);
                if (a.done || a.busy) dn++;
            end
            chk("mid_rst_no_done", dn, 0);
        end
        run4(0, -1, 64'd0, 22);
        chk_seq("s5", 1);
        if (done_cyc.size() > 0) chk("s5_done_cyc", done_cyc[0], 19);

        // 1x1 image.
        begin
            int nw, dcy, lst;
            logic [31:0] w;
            nw = 0; dcy = -1; lst = 0; w = '0;
            @(negedge clk); c.start = 1'b1;
            @(posedge clk); #1 c.start = 1'b0;
            for (int cy = 1; cy <= 10; cy++) begin
                @(negedge clk);
                if (c.m_tvalid && c.m_tready) begin nw++; w = c.m_tdata; lst = int'(c.m_tlast); end
                if (c.done && dcy < 0) dcy = cy;
                @(posedge clk); #1;
            end
            chk("one_nwords", nw, 1);
            chk("one_data", w, 32'hC0DE_0000);
            chk("one_last", lst, 1);
            chk("one_done_cyc", dcy, 4);
        end

        // 64x64 with random ready against the BRAM golden function.
        begin
            int idx, bad, nlast, ndone, cy;
            idx = 0; bad = 0; nlast = 0; ndone = 0; cy = 0;
            @(negedge clk); b.start = 1'b1;
            @(posedge clk); #1 b.start = 1'b0;
            while (ndone == 0 && cy < 20000) begin
                cy++;
                b.m_tready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (b.m_tvalid && b.m_tready) begin
                    if (b.m_tdata != big_word(32'h0001_0000 + 4 * idx)) bad++;
                    if (b.m_tlast) begin
                        nlast++;
                        if (idx != 4095) bad++;
                    end
                    idx++;
                end
                if (b.done) ndone++;
                @(posedge clk); #1;
            end
            b.m_tready = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (b.done) ndone++;
                if (b.m_tvalid) bad++;
            end
            chk("big_timeout", cy < 20000, 1);
            chk("big_nwords", idx, 4096);
            chk("big_data", bad, 0);
            chk("big_nlast", nlast, 1);
            chk("big_ndone", ndone, 1);
        end

        chk("fifo_overflow", ovf, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
